fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS core. Holds the program counter and drives the instruction-memory address. Latches the fetched word into the D stage. Consumes the D-stage branch decision (`pc_sel`, `flush`) to select the next PC and to squash the delay-slot instruction of a not-taken likely-branch.

---
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS core.
// Optional fetch-address fault detection is compiled in with `define FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic [2:0]  pc_sel,
   input  logic        flush,
   input  logic [31:0] jr_target,
   output logic [31:0] im_addr,
   input  logic [31:0] im_rdata,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        id_valid,
   output logic        id_adel
);

   typedef enum logic [2:0] {
      SEL_SEQ = 3'd0,
      SEL_BR  = 3'd1,
      SEL_J   = 3'd2,
      SEL_JR  = 3'd3
   } pc_sel_e;

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] id_pc_plus4;
   logic [31:0] br_target;
   logic [31:0] jmp_target;
   logic [31:0] next_pc;
   logic        fetch_fault;

   assign im_addr     = pc;
   assign pc_plus4    = pc + 32'd4;
   assign id_pc_plus4 = id_pc + 32'd4;
   // Branch/jump fields come from the instruction sitting in D, relative to its delay slot.
   assign br_target   = id_pc_plus4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
   assign jmp_target  = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};

   always_comb begin
      // NOTE: next_pc gets a default before the case so no path leaves it unassigned (no latch).
      next_pc = pc_plus4;
      case (pc_sel)
         SEL_BR:  next_pc = br_target;
         SEL_J:   next_pc = jmp_target;
         SEL_JR:  next_pc = jr_target;
         default: next_pc = pc_plus4;
      endcase
   end

`ifdef FETCH_ALIGN_CHECK_EN
   assign fetch_fault = (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
`else
   assign fetch_fault = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so all fields update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc       <= RESET_PC;
         id_instr <= NOP_WORD;
         id_pc    <= RESET_PC;
         id_valid <= 1'b0;
         id_adel  <= 1'b0;
      end else if (!stall) begin
         // A stall drops pc_sel/flush: the branch operands may be stale until it clears.
         pc    <= next_pc;
         id_pc <= pc;
         if (flush) begin
            id_instr <= NOP_WORD;
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
         end else if (fetch_fault) begin
            id_instr <= NOP_WORD;
            id_valid <= 1'b1;
            id_adel  <= 1'b1;
         end else begin
            id_instr <= im_rdata;
            id_valid <= 1'b1;
            id_adel  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven directed bench for fetch_unit: sequential fetch, branch/jump/jr redirect,
// flush, stall priority, PC wrap, reset mid-operation and the optional fetch-fault check.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic [2:0]  pc_sel;
   logic        flush;
   logic [31:0] jr_target;
   logic [31:0] im_addr;
   logic [31:0] im_rdata;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_valid;
   logic        id_adel;

   int n_vec = 0;
   int n_miss = 0;

   fetch_unit dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .stall     (stall),
      .pc_sel    (pc_sel),
      .flush     (flush),
      .jr_target (jr_target),
      .im_addr   (im_addr),
      .im_rdata  (im_rdata),
      .id_instr  (id_instr),
      .id_pc     (id_pc),
      .id_valid  (id_valid),
      .id_adel   (id_adel)
   );

   always #5 clk = ~clk;

   // Instruction memory: a beq at 3010 (imm -4), a j at 3020 (index C10), address-tagged words elsewhere.
   function automatic logic [31:0] im_word(input logic [31:0] a);
      case (a)
         32'h0000_3010: return 32'h1000_FFFC;
         32'h0000_3020: return 32'h0800_0C10;
         default:       return {16'hC0DE ^ a[31:16], a[15:0]};
      endcase
   endfunction

   assign im_rdata = im_word(im_addr);

   function automatic logic is_fault(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
      return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
`else
      return 1'b0;
`endif
   endfunction

   typedef struct {
      logic        stall;
      logic [2:0]  sel;
      logic        flush;
      logic [31:0] jr;
      logic [31:0] e_addr;
      logic [31:0] e_id_pc;
      logic        e_squash;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic s, input logic [2:0] sel, input logic f, input logic [31:0] jr,
                      input logic [31:0] e_addr, input logic [31:0] e_id_pc, input logic e_squash);
      vec_t v;
      v.stall = s; v.sel = sel; v.flush = f; v.jr = jr;
      v.e_addr = e_addr; v.e_id_pc = e_id_pc; v.e_squash = e_squash;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   // Compare the whole IF/ID + PC view against a squashed-or-fetched expectation at id_pc.
   task automatic check_state(input string tag, input logic [31:0] e_addr, input logic [31:0] e_id_pc,
                              input logic squash);
      logic [31:0] e_instr;
      logic        e_valid;
      logic        e_adel;
      e_adel  = !squash && is_fault(e_id_pc);
      e_valid = !squash;
      e_instr = (squash || e_adel) ? 32'h0 : im_word(e_id_pc);
      check({tag, ".im_addr"},  im_addr,  e_addr);
      check({tag, ".id_pc"},    id_pc,    e_id_pc);
      check({tag, ".id_instr"}, id_instr, e_instr);
      check({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, e_valid});
      check({tag, ".id_adel"},  {31'b0, id_adel},  {31'b0, e_adel});
   endtask

   initial begin
      //   stall sel    flush jr_target       im_addr        id_pc          squash
      add(0, 3'd0, 0, 32'h0,          32'h0000_3004, 32'h0000_3000, 0);  // first fetch
      add(0, 3'd0, 0, 32'h0,          32'h0000_3008, 32'h0000_3004, 0);
      add(0, 3'd0, 1, 32'h0,          32'h0000_300C, 32'h0000_3008, 1);  // flush while fetching 3008
      add(0, 3'd0, 0, 32'h0,          32'h0000_3010, 32'h0000_300C, 0);
      add(0, 3'd0, 0, 32'h0,          32'h0000_3014, 32'h0000_3010, 0);  // beq now in D
      add(0, 3'd1, 0, 32'h0,          32'h0000_3004, 32'h0000_3014, 0);  // taken, delay slot kept
      add(0, 3'd0, 0, 32'h0,          32'h0000_3008, 32'h0000_3004, 0);
      add(0, 3'd3, 0, 32'h0000_3020,  32'h0000_3020, 32'h0000_3008, 0);  // jr to the j
      add(0, 3'd0, 0, 32'h0,          32'h0000_3024, 32'h0000_3020, 0);  // j in D
      add(0, 3'd2, 0, 32'h0,          32'h0000_3040, 32'h0000_3024, 0);  // j -> 3040
      add(0, 3'd3, 0, 32'h0000_3100,  32'h0000_3100, 32'h0000_3040, 0);  // jr -> 3100
      add(0, 3'd5, 0, 32'h0000_7777,  32'h0000_3104, 32'h0000_3100, 0);  // sel 5 = sequential
      add(0, 3'd3, 1, 32'h0000_3200,  32'h0000_3200, 32'h0000_3104, 1);  // redirect + flush together
      add(0, 3'd0, 0, 32'h0,          32'h0000_3204, 32'h0000_3200, 0);
      add(1, 3'd2, 1, 32'h0,          32'h0000_3204, 32'h0000_3200, 0);  // stall beats j and flush
      add(1, 3'd2, 1, 32'h0,          32'h0000_3204, 32'h0000_3200, 0);
      add(1, 3'd2, 1, 32'h0,          32'h0000_3204, 32'h0000_3200, 0);
      add(0, 3'd0, 0, 32'h0,          32'h0000_3208, 32'h0000_3204, 0);  // resume, no redirect
      add(0, 3'd3, 0, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0000_3208, 0);
      add(0, 3'd0, 0, 32'h0,          32'h0000_0000, 32'hFFFF_FFFC, 0);  // pc wraps
      add(0, 3'd3, 0, 32'h0000_3002,  32'h0000_3002, 32'h0000_0000, 0);  // misaligned jr
      add(0, 3'd0, 0, 32'h0,          32'h0000_3006, 32'h0000_3002, 0);

      reset_n = 1'b0; stall = 1'b0; pc_sel = 3'd0; flush = 1'b0; jr_target = '0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset", 32'h0000_3000, 32'h0000_3000, 1'b1);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         stall = vecs[i].stall; pc_sel = vecs[i].sel; flush = vecs[i].flush; jr_target = vecs[i].jr;
         @(posedge clk);
         #1;
         check_state($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_id_pc, vecs[i].e_squash);
      end

      // Asynchronous reset in mid-cycle, then a clean restart at RESET_PC.
      stall = 1'b0; pc_sel = 3'd0; flush = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_state("async_rst", 32'h0000_3000, 32'h0000_3000, 1'b1);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_state("rst_resume0", 32'h0000_3004, 32'h0000_3000, 1'b0);
      @(posedge clk);
      #1;
      check_state("rst_resume1", 32'h0000_3008, 32'h0000_3004, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
